// File: rtl/spi_input_frontend_if.sv
// Raw SPI pins in, conditioned clk-domain levels and edge pulses out.
// The slave modport belongs to the frontend; the master modport belongs to whatever drives the pins.
interface spi_input_frontend_if;
  logic sclk;
  logic cs;
  logic mosi;
  logic c_sclk;
  logic c_cs;
  logic c_mosi;
  logic sclk_pos;
  logic sclk_neg;
  logic cs_fall;

  modport master (
    output sclk, cs, mosi,
    input  c_sclk, c_cs, c_mosi, sclk_pos, sclk_neg, cs_fall
  );

  modport slave (
    input  sclk, cs, mosi,
    output c_sclk, c_cs, c_mosi, sclk_pos, sclk_neg, cs_fall
  );
endinterface

// File: rtl/spi_input_frontend.sv
// Sync + optional glitch filter (SPI_GLITCH_FILTER_EN) for sclk/cs/mosi, plus registered edge pulses.
// Latency WAIT_CYCLES+2 edges filtered, 3 unfiltered; no backpressure, pins are sampled every cycle.
module spi_input_frontend #(
  parameter int unsigned WAIT_CYCLES = 3
) (
  input logic                 clk,
  input logic                 rst_n,
  spi_input_frontend_if.slave pins
);

  // Channel index: 0 = sclk, 1 = cs, 2 = mosi. cs idles high (deselected).
  localparam logic [2:0] RST_VAL = 3'b010;

  logic [2:0] sync0_q, sync0_d;
  logic [2:0] sync1_q, sync1_d;
  logic [2:0] cond_q, cond_d;
  logic       sclk_pos_q, sclk_pos_d;
  logic       sclk_neg_q, sclk_neg_d;
  logic       cs_fall_q, cs_fall_d;

`ifdef SPI_GLITCH_FILTER_EN
  localparam int unsigned CNT_W = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];
`endif

  always_comb begin
    sync0_d = {pins.mosi, pins.cs, pins.sclk};
    sync1_d = sync0_q;
    cond_d  = cond_q;
`ifdef SPI_GLITCH_FILTER_EN
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      // Any agreement with the accepted level discards a partial run.
      if (sync1_q[i] != cond_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          cond_d[i] = sync1_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
`else
    cond_d = sync1_q;
`endif
    sclk_pos_d = cond_d[0] & ~cond_q[0];
    sclk_neg_d = ~cond_d[0] & cond_q[0];
    cs_fall_d  = ~cond_d[1] & cond_q[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0_q    <= RST_VAL;
      sync1_q    <= RST_VAL;
      cond_q     <= RST_VAL;
      sclk_pos_q <= 1'b0;
      sclk_neg_q <= 1'b0;
      cs_fall_q  <= 1'b0;
`ifdef SPI_GLITCH_FILTER_EN
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
      end
`endif
    end else begin
      sync0_q    <= sync0_d;
      sync1_q    <= sync1_d;
      cond_q     <= cond_d;
      sclk_pos_q <= sclk_pos_d;
      sclk_neg_q <= sclk_neg_d;
      cs_fall_q  <= cs_fall_d;
`ifdef SPI_GLITCH_FILTER_EN
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
`endif
    end
  end

  assign pins.c_sclk   = cond_q[0];
  assign pins.c_cs     = cond_q[1];
  assign pins.c_mosi   = cond_q[2];
  assign pins.sclk_pos = sclk_pos_q;
  assign pins.sclk_neg = sclk_neg_q;
  assign pins.cs_fall  = cs_fall_q;

endmodule

// File: tb/tb_spi_input_frontend.sv
// Randomised and directed bench for spi_input_frontend against a sliding-window acceptance model.
module tb_spi_input_frontend;

  localparam int WC = 3;
`ifdef SPI_GLITCH_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif
  // A level is accepted once the last WEFF synchronized samples all disagree with it.
  localparam int WEFF = FILT ? WC : 1;
  localparam int LAT  = FILT ? WC + 2 : 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  spi_input_frontend_if ifc ();

  spi_input_frontend #(.WAIT_CYCLES(WC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pins  (ifc)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Behavioural model
  bit [2:0] m_s0, m_s1, m_cond, m_old;
  bit       m_pos, m_neg, m_fall, m_all;
  bit [2:0] win[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s0 = 3'b010;
      m_s1 = 3'b010;
      m_cond = 3'b010;
      m_pos = 0;
      m_neg = 0;
      m_fall = 0;
      win.delete();
    end else begin
      m_old = m_cond;
      win.push_back(m_s1);
      if (win.size() > WEFF) void'(win.pop_front());
      if (win.size() == WEFF) begin
        for (int c = 0; c < 3; c++) begin
          m_all = 1'b1;
          foreach (win[j]) if (win[j][c] == m_old[c]) m_all = 1'b0;
          if (m_all) m_cond[c] = ~m_old[c];
        end
      end
      m_pos  = m_cond[0] & ~m_old[0];
      m_neg  = ~m_cond[0] & m_old[0];
      m_fall = ~m_cond[1] & m_old[1];
      m_s1 = m_s0;
      m_s0 = {ifc.mosi, ifc.cs, ifc.sclk};
    end
  end

  // Per-cycle comparison and pulse monitoring
  int pos_cnt = 0, neg_cnt = 0, both_cnt = 0, fall_cnt = 0, cap_n = 0;
  logic [15:0] cap = '0;
  bit mon_en = 0;

  always @(negedge clk) begin
    chk("outputs_vs_model",
        int'({ifc.c_sclk, ifc.c_cs, ifc.c_mosi, ifc.sclk_pos, ifc.sclk_neg, ifc.cs_fall}),
        int'({m_cond[0], m_cond[1], m_cond[2], m_pos, m_neg, m_fall}));
    if (ifc.sclk_pos) pos_cnt++;
    if (ifc.sclk_neg) neg_cnt++;
    if (ifc.sclk_pos && ifc.sclk_neg) both_cnt++;
    if (ifc.cs_fall) fall_cnt++;
    if (mon_en && ifc.sclk_pos) begin
      cap = {cap[14:0], ifc.c_mosi};
      cap_n++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  int n, p0, q0, f0, b0;
  logic [15:0] word;
  int hold[3];

  initial begin
    ifc.sclk = 1'b1;
    ifc.cs   = 1'b0;
    ifc.mosi = 1'b1;
    #1 rst_n = 1'b0;
    tick(3);
    chk("rst_c_cs", ifc.c_cs, 1);
    chk("rst_c_sclk", ifc.c_sclk, 0);
    chk("rst_c_mosi", ifc.c_mosi, 0);
    chk("rst_pulses", int'({ifc.sclk_pos, ifc.sclk_neg, ifc.cs_fall}), 0);

    // Release with pins held away from their reset values.
    rst_n = 1'b1;
    n = 0;
    while (n < 20 && ifc.c_cs) begin
      @(posedge clk); #1; n++;
    end
    chk("release_latency", n, LAT);
    chk("release_cs_fall", ifc.cs_fall, 1);
    chk("release_c_mosi", ifc.c_mosi, 1);
    chk("release_c_sclk", ifc.c_sclk, 1);

    ifc.sclk = 1'b0; ifc.cs = 1'b1; ifc.mosi = 1'b0;
    tick(12);

    // Rising sclk latency and single-cycle pulse
    ifc.sclk = 1'b1;
    n = 0;
    while (n < 20 && !ifc.c_sclk) begin
      @(posedge clk); #1; n++;
    end
    chk("sclk_rise_latency", n, LAT);
    chk("sclk_pos_high", ifc.sclk_pos, 1);
    tick(1);
    chk("sclk_pos_low", ifc.sclk_pos, 0);
    ifc.sclk = 1'b0;
    tick(12);

    // cs glitches of 2 and 3 cycles
    f0 = fall_cnt;
    ifc.cs = 1'b0; tick(2); ifc.cs = 1'b1; tick(12);
    chk("cs_glitch2_falls", fall_cnt - f0, FILT ? 0 : 1);
    chk("cs_glitch2_level", ifc.c_cs, 1);
    f0 = fall_cnt;
    ifc.cs = 1'b0; tick(3); ifc.cs = 1'b1; tick(12);
    chk("cs_glitch3_falls", fall_cnt - f0, 1);

    // One-cycle sclk glitch
    p0 = pos_cnt; q0 = neg_cnt;
    ifc.sclk = 1'b1; tick(1); ifc.sclk = 1'b0; tick(12);
    chk("sclk_glitch1_pos", pos_cnt - p0, FILT ? 0 : 1);
    chk("sclk_glitch1_neg", neg_cnt - q0, FILT ? 0 : 1);

    // 16-bit frame, sclk period 8 clk, mosi changes with sclk fall
    ifc.cs = 1'b0; tick(8);
    word = 16'($urandom_range(0, 65535));
    p0 = pos_cnt; q0 = neg_cnt; b0 = both_cnt; cap_n = 0;
    mon_en = 1;
    for (int b = 15; b >= 0; b--) begin
      ifc.mosi = word[b];
      ifc.sclk = 1'b0;
      tick(4);
      ifc.sclk = 1'b1;
      tick(4);
    end
    ifc.sclk = 1'b0;
    tick(10);
    mon_en = 0;
    ifc.cs = 1'b1;
    tick(12);
    chk("frame_pos_count", pos_cnt - p0, 16);
    chk("frame_neg_count", neg_cnt - q0, 16);
    chk("frame_coincident", both_cnt - b0, 0);
    chk("frame_captures", cap_n, 16);
    chk("frame_mosi_word", int'(cap), int'(word));

    // Reset during a pending cs acceptance
    ifc.cs = 1'b0; tick(4);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_c_cs", ifc.c_cs, 1);
    chk("midrst_levels", int'({ifc.c_sclk, ifc.c_mosi}), 0);
    chk("midrst_pulses", int'({ifc.sclk_pos, ifc.sclk_neg, ifc.cs_fall}), 0);
    ifc.cs = 1'b1;
    tick(2);
    rst_n = 1'b1;
    f0 = fall_cnt;
    tick(20);
    chk("midrst_no_fall", fall_cnt - f0, 0);
    chk("midrst_c_cs_after", ifc.c_cs, 1);

    // Random pin activity with occasional resets
    for (int c = 0; c < 3; c++) hold[c] = 1;
    repeat (3000) begin
      for (int c = 0; c < 3; c++) begin
        hold[c]--;
        if (hold[c] == 0) begin
          case (c)
            0: ifc.sclk = ~ifc.sclk;
            1: ifc.cs   = ~ifc.cs;
            default: ifc.mosi = ~ifc.mosi;
          endcase
          hold[c] = $urandom_range(1, 8);
        end
      end
      rst_n = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      tick(1);
    end
    rst_n = 1'b1;
    tick(12);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_input_frontend.md
# spi_input_frontend

Conditions the three raw SPI pins (sclk, cs, mosi) into the clean, clk-domain signals consumed by the SPI control FSM. Each pin is double-flop synchronized and glitch-filtered. The block emits single-cycle pulses on serial-clock rising and falling edges and on chip-select assertion. It sits directly upstream of the FSM: c_cs drives the FSM's c_cs input, and sclk_pos drives its peripheralClkEdge input.

## Interface
- WAIT_CYCLES, 3: consecutive clk cycles a synchronized input must hold a new value before it is accepted; legal range 1..255.
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- sclk  input  1  raw SPI serial clock pin, asynchronous to clk.
- cs  input  1  raw SPI chip select pin, active-low, asynchronous.
- mosi  input  1  raw SPI data-in pin, asynchronous.
- c_sclk  output  1  conditioned serial clock level.
- c_cs  output  1  conditioned chip select level; feeds FSM c_cs.
- c_mosi  output  1  conditioned MOSI level; feeds shift-register serial input.
- sclk_pos  output  1  one-cycle pulse when c_sclk rises; feeds FSM peripheralClkEdge.
- sclk_neg  output  1  one-cycle pulse when c_sclk falls; used for MISO launch.
- cs_fall  output  1  one-cycle pulse when c_cs falls (frame start).

## Operation
- Three identical channels: sclk, cs, mosi. Each channel has sync0 → sync1 (2-flop synchronizer), a counter, and a registered conditioned level.
- Counter width: smallest width holding WAIT_CYCLES-1; minimum 1 bit.
- Per channel, on each clk rising edge, with the filter compiled in:
  - If sync1 == conditioned: counter <= 0.
  - Else if counter == WAIT_CYCLES-1: conditioned <= sync1; counter <= 0.
  - Else: counter <= counter + 1.
- A disagreement that ends before acceptance returns the counter to 0. The glitch is discarded and the output is unchanged.
- Edge pulses are registered. Each is asserted on the same edge at which its conditioned level changes, and deasserted on the next edge.
- sclk_pos and sclk_neg are mutually exclusive by construction.
- cs_fall has no rising counterpart. The FSM detects frame end from the c_cs level.
- Channels are fully independent. Simultaneous transitions on several pins are each processed in parallel with identical latency.
- Reset values, applied asynchronously:
  - sclk: sync0 = sync1 = 0, c_sclk = 0.
  - cs: sync0 = sync1 = 1, c_cs = 1 (deselected).
  - mosi: sync0 = sync1 = 0, c_mosi = 0.
  - All counters 0; sclk_pos = sclk_neg = cs_fall = 0.
- Reset mid-filtering aborts any pending acceptance. No pulse is emitted on reset assertion or release.

## Timing
- Pin changes and is stable before clk edge N: sync0 updates at N, sync1 at N+1.
- With filter: conditioned level and pulse update at edge N+1+WAIT_CYCLES. Total latency WAIT_CYCLES+2 edges. Default: 5 edges.
- Without filter: conditioned level and pulse update at edge N+2. Latency 3 edges.
- Accepted pin pulse width: at least WAIT_CYCLES clk periods, measured at sync1.
- Maximum supported sclk frequency with filter: clk / (2·(WAIT_CYCLES+1)).
- Pulse outputs are high for exactly one clk period.

## Configuration
- SPI_GLITCH_FILTER_EN defined: counters present; behaviour as above; WAIT_CYCLES honoured.
- SPI_GLITCH_FILTER_EN not defined:
  - Counters omitted; WAIT_CYCLES ignored.
  - conditioned <= sync1 on every edge.
  - Pulses fire on every change of sync1.
  - Reset values unchanged.

## Test plan
- Reset: hold rst_n=0 with pins at sclk=1, cs=0, mosi=1. Required: c_cs=1, c_sclk=0, c_mosi=0, all pulses 0. Release rst_n with pins stable; with WAIT_CYCLES=3, c_cs falls and cs_fall pulses exactly 5 edges after release, with c_mosi and c_sclk rising on the same edge.
- Latency (filter on, WAIT_CYCLES=3): sclk 0→1 before edge N. Required: c_sclk=1 and sclk_pos=1 after edge N+4; sclk_pos=0 after N+5.
- Glitch rejection: cs high, drop cs low for 2 clk periods, then back high. Required: c_cs stays 1 and cs_fall never asserts. Repeat with 3 periods: c_cs falls and cs_fall pulses once.
- Full SPI clocking: cs low, then 16 sclk periods of 8 clk each, mosi toggling on sclk falling. Required: 16 sclk_pos and 16 sclk_neg pulses, never coincident; c_mosi stable on every sclk_pos.
- Reset mid-operation: assert rst_n=0 while a cs transition is 2 cycles into filtering. Required: outputs return to reset values immediately; no cs_fall pulse afterwards unless the pin remains low for the full latency after release.
- Filter compiled out: sclk 0→1 before edge N. Required: sclk_pos after edge N+2; a 1-cycle pin glitch produces one pulse on each edge.
